tmp1075_ctrl: RTL and testbench

TMP1075_CTRL -- requirements
Module: tmp1075_ctrl

---
 rtl/tmp1075_ctrl_if.sv | 23 ++
 rtl/tmp1075_ctrl.sv | 174 +++++++++++++++++
 tb/tb_tmp1075_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmp1075_ctrl_if.sv
// Command/response bus between tmp1075_ctrl and the i2c_dri bit engine.
interface tmp1075_ctrl_if;
    logic        i2c_exec;
    logic        bit_ctrl;
    logic        i2c_rh_wl;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic [7:0]  i2c_data_r;
    logic        i2c_done;
    logic        i2c_ack;

    // Controller side: issues commands, receives completions.
    modport master (
        output i2c_exec, bit_ctrl, i2c_rh_wl, i2c_addr, i2c_data_w,
        input  i2c_data_r, i2c_done, i2c_ack
    );

    // i2c_dri side: accepts commands, returns completions.
    modport slave (
        input  i2c_exec, bit_ctrl, i2c_rh_wl, i2c_addr, i2c_data_w,
        output i2c_data_r, i2c_done, i2c_ack
    );
endinterface

// File: rtl/tmp1075_ctrl.sv
// TMP1075 controller: writes the config register once, then polls the
// temperature register every POLL_CYCLES clocks while start is held.
// Optional feature macro: TMP1075_NACK_RETRY_EN (re-issue a NACKed
// transaction up to 3 times before flagging err).
module tmp1075_ctrl #(
    parameter logic [7:0]  CFG_HI      = 8'h61,
    parameter logic [7:0]  CFG_LO      = 8'hA0,
    parameter int unsigned POLL_CYCLES = 10_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    tmp1075_ctrl_if.master        bus,
    output logic [15:0]           temp_data,
    output logic                  temp_valid,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned CMD_W = 25;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG_H = 3'd1,
        CFG_L = 3'd2,
        PTR   = 3'd3,
        RD_H  = 3'd4,
        RD_L  = 3'd5,
        WAIT  = 3'd6
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         shadow;
    logic               cfg_done;
    logic               exec_q;
    logic               bit_ctrl_q;
    logic [CMD_W-1:0]   cmd;
`ifdef TMP1075_NACK_RETRY_EN
    logic [1:0]         retry_cnt;
`endif

    // Command word {rh_wl, addr, data_w} issued on entry to each bus state.
    function automatic logic [CMD_W-1:0] cmd_of(input state_t s);
        case (s)
            CFG_H:      cmd_of = {1'b0, 16'h0001, CFG_HI};
            CFG_L:      cmd_of = {1'b0, 16'h0001, CFG_LO};
            PTR:        cmd_of = {1'b0, 16'h0000, 8'h00};
            RD_H, RD_L: cmd_of = {1'b1, 16'h0000, 8'h00};
            default:    cmd_of = '0;
        endcase
    endfunction

    assign bus.i2c_exec = exec_q;
    assign bus.bit_ctrl = bit_ctrl_q;
    assign {bus.i2c_rh_wl, bus.i2c_addr, bus.i2c_data_w} = cmd;

    // Sequencer: state, poll counter, command register and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= 8'h00;
            cfg_done   <= 1'b0;
            exec_q     <= 1'b0;
            bit_ctrl_q <= 1'b0;
            cmd        <= '0;
            temp_data  <= 16'h0000;
            temp_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
`ifdef TMP1075_NACK_RETRY_EN
            retry_cnt  <= 2'd0;
`endif
        end else begin
            exec_q     <= 1'b0;
            bit_ctrl_q <= 1'b0;
            temp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        exec_q <= 1'b1;
                        if (cfg_done) begin
                            state <= PTR;
                            cmd   <= cmd_of(PTR);
                        end else begin
                            state <= CFG_H;
                            cmd   <= cmd_of(CFG_H);
                        end
                    end
                end
                WAIT: begin
                    if (!start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(POLL_CYCLES - 1)) begin
                        cnt    <= '0;
                        state  <= PTR;
                        cmd    <= cmd_of(PTR);
                        exec_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // Completion is only accepted once the issue cycle is over.
                    if (bus.i2c_done && !exec_q) begin
                        if (bus.i2c_ack) begin
`ifdef TMP1075_NACK_RETRY_EN
                            if (retry_cnt != 2'd3) begin
                                retry_cnt <= retry_cnt + 2'd1;
                                exec_q    <= 1'b1;
                            end else begin
                                retry_cnt <= 2'd0;
                                err       <= 1'b1;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end
`else
                            err   <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
`endif
                        end else begin
`ifdef TMP1075_NACK_RETRY_EN
                            retry_cnt <= 2'd0;
`endif
                            case (state)
                                CFG_H: begin
                                    state  <= CFG_L;
                                    cmd    <= cmd_of(CFG_L);
                                    exec_q <= 1'b1;
                                end
                                CFG_L: begin
                                    cfg_done <= 1'b1;
                                    state    <= WAIT;
                                end
                                PTR: begin
                                    state  <= RD_H;
                                    cmd    <= cmd_of(RD_H);
                                    exec_q <= 1'b1;
                                end
                                RD_H: begin
                                    shadow <= bus.i2c_data_r;
                                    state  <= RD_L;
                                    cmd    <= cmd_of(RD_L);
                                    exec_q <= 1'b1;
                                end
                                RD_L: begin
                                    temp_data  <= {shadow, bus.i2c_data_r};
                                    temp_valid <= 1'b1;
                                    if (start) begin
                                        state <= WAIT;
                                    end else begin
                                        state <= IDLE;
                                        busy  <= 1'b0;
                                    end
                                end
                                default: begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmp1075_ctrl.sv
// Scoreboard bench for tmp1075_ctrl with a behavioural i2c_dri slave.
module tb_tmp1075_ctrl;

    localparam int unsigned POLL = 20;
    localparam int          DLY  = 4;
`ifdef TMP1075_NACK_RETRY_EN
    localparam int          NACK_ISSUES = 4;
`else
    localparam int          NACK_ISSUES = 1;
`endif

    typedef struct {
        logic        rh_wl;
        logic [15:0] addr;
        logic [7:0]  data;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] temp_data;
    logic        temp_valid;
    logic        busy;
    logic        err;

    tmp1075_ctrl_if bus();

    tmp1075_ctrl #(
        .CFG_HI      (8'h61),
        .CFG_LO      (8'hA0),
        .POLL_CYCLES (POLL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .temp_data  (temp_data),
        .temp_valid (temp_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    cmd_t        exp_cmd[$];
    logic [15:0] exp_temp[$];
    logic [7:0]  rd_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_tv = 0;
    int n_exec = 0;
    int last_tv_cyc = 0;
    int last_exec_cyc = 0;
    int last_done_cyc = 0;
    bit nack_all = 1'b0;
    bit nack_rd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic cmd_t mk(input logic rh_wl, input logic [15:0] addr, input logic [7:0] data);
        cmd_t c;
        c.rh_wl = rh_wl;
        c.addr  = addr;
        c.data  = data;
        return c;
    endfunction

    task automatic push_cfg();
        exp_cmd.push_back(mk(1'b0, 16'h0001, 8'h61));
        exp_cmd.push_back(mk(1'b0, 16'h0001, 8'hA0));
    endtask

    task automatic push_poll(input logic [7:0] hi, input logic [7:0] lo);
        exp_cmd.push_back(mk(1'b0, 16'h0000, 8'h00));
        exp_cmd.push_back(mk(1'b1, 16'h0000, 8'h00));
        exp_cmd.push_back(mk(1'b1, 16'h0000, 8'h00));
        rd_q.push_back(hi);
        rd_q.push_back(lo);
        exp_temp.push_back({hi, lo});
    endtask

    task automatic wait_tv(input int n);
        for (int i = 0; i < 3000 && n_tv < n; i++) @(negedge clk);
        if (n_tv < n) fail_now("timeout_temp_valid");
    endtask

    task automatic wait_exec(input int n);
        for (int i = 0; i < 3000 && n_exec < n; i++) @(negedge clk);
        if (n_exec < n) fail_now("timeout_exec");
    endtask

    // Behavioural i2c_dri: completes each command DLY clocks after exec.
    bit s_open = 1'b0;
    bit s_rd = 1'b0;
    int s_cnt = 0;
    initial begin
        bus.i2c_done   = 1'b0;
        bus.i2c_ack    = 1'b0;
        bus.i2c_data_r = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_open       = 1'b0;
                s_cnt        = 0;
                bus.i2c_done = 1'b0;
            end else begin
                bus.i2c_done = 1'b0;
                if (s_open) begin
                    s_cnt--;
                    if (s_cnt == 0) begin
                        bus.i2c_done   = 1'b1;
                        bus.i2c_ack    = nack_all || (nack_rd && s_rd);
                        bus.i2c_data_r = 8'h00;
                        if (s_rd && !bus.i2c_ack && rd_q.size() > 0)
                            bus.i2c_data_r = rd_q.pop_front();
                        s_open        = 1'b0;
                        last_done_cyc = cyc;
                    end
                end else if (bus.i2c_exec) begin
                    s_open = 1'b1;
                    s_cnt  = DLY;
                    s_rd   = bus.i2c_rh_wl;
                end
            end
        end
    end

    // Command monitor: every exec pulse is checked against the expected queue.
    bit m_open = 1'b0;
    bit prev_exec = 1'b0;
    always @(negedge clk) begin
        cmd_t e;
        if (!rst_n) begin
            m_open    = 1'b0;
            prev_exec = 1'b0;
        end else begin
            if (bus.i2c_done) m_open = 1'b0;
            if (bus.i2c_exec) begin
                n_exec++;
                last_exec_cyc = cyc;
                chk("exec_single_pulse", int'(prev_exec), 0);
                chk("exec_while_pending", int'(m_open), 0);
                chk("bit_ctrl", int'(bus.bit_ctrl), 0);
                if (exp_cmd.size() == 0) begin
                    fail_now("unexpected_exec");
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd_rh_wl", int'(bus.i2c_rh_wl), int'(e.rh_wl));
                    chk("cmd_addr", int'(bus.i2c_addr), int'(e.addr));
                    if (!e.rh_wl) chk("cmd_data", int'(bus.i2c_data_w), int'(e.data));
                end
                m_open = 1'b1;
            end
            prev_exec = bus.i2c_exec;
        end
    end

    // Temperature monitor: value, pulse width and latency from final done.
    bit prev_tv = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_tv = 1'b0;
        end else begin
            if (temp_valid) begin
                n_tv++;
                chk("tv_single_pulse", int'(prev_tv), 0);
                chk("tv_latency", cyc, last_done_cyc + 1);
                if (exp_temp.size() == 0) fail_now("unexpected_temp_valid");
                else chk("temp_data", int'(temp_data), int'(exp_temp.pop_front()));
                last_tv_cyc = cyc;
            end
            prev_tv = temp_valid;
        end
    end

    initial begin
        int base;
        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_temp_data", int'(temp_data), 0);
        chk("rst_temp_valid", int'(temp_valid), 0);
        chk("rst_exec", int'(bus.i2c_exec), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Config + first poll, then a second poll without config.
        push_cfg();
        push_poll(8'h19, 8'h40);
        start = 1'b1;
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        wait_tv(1);
        push_poll(8'h12, 8'h34);
        wait_exec(6);
        chk("poll_interval", last_exec_cyc - last_tv_cyc, int'(POLL));

        // Drop start while RD_L is in flight.
        wait_exec(8);
        start = 1'b0;
        wait_tv(2);
        repeat (3 * POLL) @(negedge clk);
        chk("idle_after_stop", int'(busy), 0);
        chk("stop_cmds_drained", exp_cmd.size(), 0);

        // Reset during RD_H.
        exp_cmd.push_back(mk(1'b0, 16'h0000, 8'h00));
        exp_cmd.push_back(mk(1'b1, 16'h0000, 8'h00));
        start = 1'b1;
        wait_exec(10);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_temp_data", int'(temp_data), 0);
        rd_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_cfg();
        push_poll(8'hAB, 8'hCD);
        start = 1'b1;
        wait_tv(3);
        start = 1'b0;
        repeat (POLL + 10) @(negedge clk);
        chk("rerun_busy", int'(busy), 0);
        chk("rerun_temp", int'(temp_data), 16'hABCD);
        chk("rerun_err", int'(err), 0);

        // NACK on reads: err set, temp_data unchanged.
        nack_rd = 1'b1;
        exp_cmd.push_back(mk(1'b0, 16'h0000, 8'h00));
        for (int i = 0; i < NACK_ISSUES; i++) exp_cmd.push_back(mk(1'b1, 16'h0000, 8'h00));
        base = n_exec;
        start = 1'b1;
        wait_exec(base + 1);
        start = 1'b0;
        repeat (80) @(negedge clk);
        chk("rdnack_err", int'(err), 1);
        chk("rdnack_busy", int'(busy), 0);
        chk("rdnack_temp", int'(temp_data), 16'hABCD);
        chk("rdnack_issues", n_exec - base, 1 + NACK_ISSUES);
        nack_rd = 1'b0;

        // NACK on CFG_H after reset.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_clears_err", int'(err), 0);
        nack_all = 1'b1;
        for (int i = 0; i < NACK_ISSUES; i++) exp_cmd.push_back(mk(1'b0, 16'h0001, 8'h61));
        base = n_exec;
        start = 1'b1;
        wait_exec(base + 1);
        start = 1'b0;
        repeat (80) @(negedge clk);
        chk("cfgnack_err", int'(err), 1);
        chk("cfgnack_busy", int'(busy), 0);
        chk("cfgnack_temp", int'(temp_data), 0);
        chk("cfgnack_issues", n_exec - base, NACK_ISSUES);
        nack_all = 1'b0;

        chk("cmd_queue_empty", exp_cmd.size(), 0);
        chk("temp_queue_empty", exp_temp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
